// File: rtl/seq_dec.sv
// seq_dec: serial sequence decoder.
// Watches a 1-bit line for START/STOP words, rebuilds the framed flag level,
// counts completed frames and traps frames that run past MAX_LEN bits.
module seq_dec #(
    parameter int              PAT_W     = 4,
    parameter logic [PAT_W-1:0] START_PAT = 4'b1101,
    parameter logic [PAT_W-1:0] STOP_PAT  = 4'b0110,
    parameter int              MAX_LEN   = 16,
    parameter int              CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sm_in,
    output logic             flag_out,
    output logic             start_det,
    output logic             stop_det,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_ERROR  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] sr_q, sr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             start_det_q, start_det_d;
    logic             stop_det_q, stop_det_d;
    logic             err_q, err_d;

    logic             cmp_en;
    logic             start_hit;
    logic             stop_hit;

    // Next-state logic: compare on the post-shift window so a match is
    // registered at the same edge that samples the word's last bit.
    always_comb begin
        sr_d        = {sr_q[PAT_W-2:0], sm_in};
        // Window holds PAT_W fresh bits once this edge's bit is included.
        cmp_en      = (fill_q >= FILL_W'(PAT_W - 1));
        start_hit   = cmp_en && (sr_d == START_PAT);
        stop_hit    = cmp_en && (sr_d == STOP_PAT);

        state_d     = state_q;
        len_d       = '0;
        cnt_d       = cnt_q;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        fill_d      = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);

        case (state_q)
            S_IDLE: begin
                // STOP in IDLE is ignored entirely, fill keeps counting.
                if (start_hit) begin
                    state_d     = S_ACTIVE;
                    start_det_d = 1'b1;
                    fill_d      = '0;
                end
            end
            S_ACTIVE: begin
                // STOP on the last allowed bit takes priority over timeout.
                if (stop_hit) begin
                    state_d    = S_IDLE;
                    stop_det_d = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    fill_d     = '0;
                end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    len_d = len_q + LEN_W'(1);
                end
            end
            S_ERROR: begin
                // Silent recovery: no pulse, no count.
                if (stop_hit) begin
                    state_d = S_IDLE;
                    fill_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        flag_d = (state_d == S_ACTIVE);
        err_d  = (state_d == S_ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            fill_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            err_q       <= err_d;
        end
    end

    assign flag_out  = flag_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign err       = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_seq_dec.sv
// Bench for seq_dec: a table of {reset, bit, expected outputs} rows is built
// up front, driven one row per cycle, and expected outputs go through a
// scoreboard queue that is popped after each rising edge.
module tb_seq_dec;

    logic       clk;
    logic       reset;
    logic       sm_in;
    logic       flag_out;
    logic       start_det;
    logic       stop_det;
    logic       err;
    logic [7:0] frame_cnt;

    typedef struct {
        logic        rst;
        logic        b;
        logic [11:0] exp;   // {flag_out, start_det, stop_det, err, frame_cnt}
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] sb[$];
    int          sb_id[$];
    int          checks;
    int          failures;
    logic [11:0] mon_exp;
    logic [11:0] mon_act;
    int          mon_id;

    seq_dec dut (
        .clk       (clk),
        .reset     (reset),
        .sm_in     (sm_in),
        .flag_out  (flag_out),
        .start_det (start_det),
        .stop_det  (stop_det),
        .err       (err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row: drive r/b for a cycle, expect the listed outputs after the edge.
    task automatic add(input logic r, input logic b, input logic f, input logic sd,
                       input logic pd, input logic er, input logic [7:0] c);
        vec_t v;
        v.rst = r;
        v.b   = b;
        v.exp = {f, sd, pd, er, c};
        tbl.push_back(v);
    endtask

    // n bits MSB-first from bits, all with the same expected outputs.
    task automatic seq(input int n, input logic [31:0] bits, input logic f, input logic sd,
                       input logic pd, input logic er, input logic [7:0] c);
        for (int i = n - 1; i >= 0; i--) add(1'b0, bits[i], f, sd, pd, er, c);
    endtask

    // Compare DUT outputs one time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_id  = sb_id.pop_front();
            mon_act = {flag_out, start_det, stop_det, err, frame_cnt};
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL row%0d {flag,start,stop,err,cnt}: got %b_%0d want %b_%0d",
                         mon_id, mon_act[11:8], mon_act[7:0], mon_exp[11:8], mon_exp[7:0]);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        sm_in    = 1'b0;

        // Reset and idle line
        add(1'b1, 1'b0, 0, 0, 0, 0, 8'd0);
        add(1'b1, 1'b0, 0, 0, 0, 0, 8'd0);
        seq(10, 0, 0, 0, 0, 0, 8'd0);
        // START 1101 (window passes 0110 on the way, ignored in IDLE)
        seq(3, 3'b110, 0, 0, 0, 0, 8'd0);
        seq(1, 1,      1, 1, 0, 0, 8'd0);
        // STOP 0110 closes the frame
        seq(3, 3'b011, 1, 0, 0, 0, 8'd0);
        seq(1, 0,      0, 0, 1, 0, 8'd1);
        // A trailing 1 would form 1101 with STOP bits: must not start
        seq(1, 1,      0, 0, 0, 0, 8'd1);
        // Fresh START needs four new bits
        seq(3, 3'b110, 0, 0, 0, 0, 8'd1);
        seq(1, 1,      1, 1, 0, 0, 8'd1);
        // Timeout: 15 zeros still active, 16th enters ERROR
        seq(15, 0,     1, 0, 0, 0, 8'd1);
        seq(1, 0,      0, 0, 0, 1, 8'd1);
        // START ignored in ERROR
        seq(5, 5'b11101, 0, 0, 0, 1, 8'd1);
        // STOP exits ERROR silently
        seq(3, 3'b011, 0, 0, 0, 1, 8'd1);
        seq(1, 0,      0, 0, 0, 0, 8'd1);
        // STOP completing on the 16th active bit wins over timeout
        seq(3, 3'b110, 0, 0, 0, 0, 8'd1);
        seq(1, 1,      1, 1, 0, 0, 8'd1);
        seq(12, 32'hfff, 1, 0, 0, 0, 8'd1);
        seq(3, 3'b011, 1, 0, 0, 0, 8'd1);
        seq(1, 0,      0, 0, 1, 0, 8'd2);
        // Reset mid-frame: no pulse, counter cleared
        seq(3, 3'b110, 0, 0, 0, 0, 8'd2);
        seq(1, 1,      1, 1, 0, 0, 8'd2);
        seq(2, 0,      1, 0, 0, 0, 8'd2);
        add(1'b1, 1'b0, 0, 0, 0, 0, 8'd0);
        // STOP from IDLE does nothing
        seq(4, 4'b0110, 0, 0, 0, 0, 8'd0);
        // Encoder-style frame: idle, START, payload of ones, STOP
        seq(4, 0,      0, 0, 0, 0, 8'd0);
        seq(3, 3'b110, 0, 0, 0, 0, 8'd0);
        seq(1, 1,      1, 1, 0, 0, 8'd0);
        seq(4, 4'hf,   1, 0, 0, 0, 8'd0);
        seq(3, 3'b011, 1, 0, 0, 0, 8'd0);
        seq(1, 0,      0, 0, 1, 0, 8'd1);
        // Back-to-back minimal frames until the counter wraps to 0
        for (int k = 2; k <= 256; k++) begin
            seq(3, 3'b110, 0, 0, 0, 0, 8'(k - 1));
            seq(1, 1,      1, 1, 0, 0, 8'(k - 1));
            seq(3, 3'b011, 1, 0, 0, 0, 8'(k - 1));
            seq(1, 0,      0, 0, 1, 0, 8'(k));
        end
        seq(2, 0,      0, 0, 0, 0, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst;
            sm_in = tbl[i].b;
            sb.push_back(tbl[i].exp);
            sb_id.push_back(i);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
